// File: rtl/bg_painter_pkg.sv
// Shared constants, state encoding and address helper for the background painter.
package bg_pkg;

  localparam int SCREEN_W = 320;
  localparam int SCREEN_H = 240;
  localparam int BG_BYTES = 38400;

  // Last row and last byte column of the half-resolution frame (two pixels per byte).
  localparam logic [7:0] LAST_ROW  = 8'd239;
  localparam logic [7:0] LAST_BCOL = 8'd159;

  // Default palette indices.
  localparam logic [3:0] DEF_SKY_IDX   = 4'h1;
  localparam logic [3:0] DEF_GRASS_IDX = 4'h2;
  localparam logic [3:0] DEF_DIRT_IDX  = 4'h3;
  localparam int         DEF_GRASS_ROWS = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    CR_RD = 2'd2,
    CR_WR = 2'd3
  } bg_state_t;

  // Byte address of byte column xb (pixel x = 2*xb, 2*xb+1) on row y: y*160 + xb.
  function automatic logic [15:0] byte_addr(input logic [7:0] y, input logic [7:0] xb);
    return ({8'd0, y} << 7) + ({8'd0, y} << 5) + {8'd0, xb};
  endfunction

endpackage

// File: rtl/bg_painter_terrain_height.sv
// Terrain surface row for a half-res column: g(x) = 150 + ((x-160)^2 >> 9), range 150..200.
module terrain_height (
  input  logic [8:0] x,
  output logic [7:0] g
);

  logic signed [9:0] dx;
  logic        [9:0] adx;
  logic        [16:0] sq;

  // Parabola around the screen centre; squaring the magnitude keeps the product unsigned.
  always_comb begin
    dx  = $signed({1'b0, x}) - 10'sd160;
    adx = dx[9] ? 10'(-dx) : 10'(dx);
    sq  = {7'd0, adx} * {7'd0, adx};
    g   = 8'd150 + 8'(sq >> 9);
  end

endmodule

// File: rtl/bg_painter.sv
// Background frame-buffer writer: full terrain repaint or read-modify-write crater punch.
//
// Request protocol: fill_start and crater_req are single-cycle pulses that are only
// accepted while the FSM is IDLE (busy=0, which includes the cycle done is high);
// pulses seen while busy are dropped, and fill_start wins over a simultaneous crater_req.
// Completion is signalled by a one-cycle done pulse together with busy falling.
module bg_painter
  import bg_pkg::*;
#(
  parameter logic [3:0] SKY_IDX    = DEF_SKY_IDX,
  parameter logic [3:0] GRASS_IDX  = DEF_GRASS_IDX,
  parameter logic [3:0] DIRT_IDX   = DEF_DIRT_IDX,
  parameter int         GRASS_ROWS = DEF_GRASS_ROWS
) (
  input  logic        VGA_Clk,
  input  logic        Reset,
  input  logic        fill_start,
  input  logic        crater_req,
  input  logic [8:0]  crater_x,
  input  logic [7:0]  crater_y,
  input  logic [3:0]  crater_r,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_wdata,
  output logic        mem_we,
  input  logic [7:0]  mem_rdata,
  output logic        busy,
  output logic        done,
  output bg_state_t   dbg_state
);

  bg_state_t state, state_d;

  // Position of the byte currently on the memory port, and the one for next cycle.
  logic [7:0] cur_y, cur_xb, nxt_y, nxt_xb;

  // Crater parameters and clamped region, captured when the request is accepted.
  logic [8:0] cx;
  logic [7:0] cy;
  logic [3:0] cr;
  logic [7:0] row_lo, row_hi, bcol_lo, bcol_hi;

  logic we_d, busy_d, done_d, latch_req;
  logic [7:0] wdata_q;

  // ---------------------------------------------------------------------------
  // Crater bounds from the request inputs
  // ---------------------------------------------------------------------------
  logic signed [10:0] req_cx, req_cy, req_r;
  logic signed [10:0] lo_y, hi_y, lo_x, hi_x;
  logic [7:0] req_row_lo, req_row_hi, req_bcol_lo, req_bcol_hi;

  // Clamp the bounding box to the screen and widen columns to whole bytes.
  always_comb begin
    req_cx = $signed({2'b00, crater_x});
    req_cy = $signed({3'b000, crater_y});
    req_r  = $signed({7'd0, crater_r});
    lo_y   = req_cy - req_r;
    hi_y   = req_cy + req_r;
    lo_x   = req_cx - req_r;
    hi_x   = req_cx + req_r;
    req_row_lo  = (lo_y < 0)         ? 8'd0     : 8'(lo_y);
    req_row_hi  = (hi_y > 11'sd239)  ? LAST_ROW : 8'(hi_y);
    // Rounding x down to even / up to odd is the same byte column as x>>1.
    req_bcol_lo = (lo_x < 0)         ? 8'd0      : 8'(lo_x >> 1);
    req_bcol_hi = (hi_x > 11'sd319)  ? LAST_BCOL : 8'(hi_x >> 1);
  end

  // ---------------------------------------------------------------------------
  // Fill data for the next byte position
  // ---------------------------------------------------------------------------
  logic [7:0] g_even, g_odd;
  logic [3:0] nib_even, nib_odd;
  logic [7:0] fill_byte;

  terrain_height u_height_even (.x({nxt_xb, 1'b0}), .g(g_even));
  terrain_height u_height_odd  (.x({nxt_xb, 1'b1}), .g(g_odd));

  // Sky above the surface, a grass band of GRASS_ROWS rows, dirt below.
  always_comb begin
    if (nxt_y < g_even)
      nib_even = SKY_IDX;
    else if ({1'b0, nxt_y} < ({1'b0, g_even} + 9'(GRASS_ROWS)))
      nib_even = GRASS_IDX;
    else
      nib_even = DIRT_IDX;
    if (nxt_y < g_odd)
      nib_odd = SKY_IDX;
    else if ({1'b0, nxt_y} < ({1'b0, g_odd} + 9'(GRASS_ROWS)))
      nib_odd = GRASS_IDX;
    else
      nib_odd = DIRT_IDX;
    fill_byte = {nib_even, nib_odd};
  end

  // ---------------------------------------------------------------------------
  // Crater merge for the byte currently being written
  // ---------------------------------------------------------------------------
  logic signed [21:0] dx_e, dx_o, dy, dist_e, dist_o;
  logic [7:0] r_sq;
  logic [7:0] crater_byte;

  // Nibbles inside the circle turn to sky; the rest keep what was read back.
  always_comb begin
    dx_e   = $signed({13'd0, cur_xb, 1'b0}) - $signed({13'd0, cx});
    dx_o   = $signed({13'd0, cur_xb, 1'b1}) - $signed({13'd0, cx});
    dy     = $signed({14'd0, cur_y}) - $signed({14'd0, cy});
    dist_e = dx_e * dx_e + dy * dy;
    dist_o = dx_o * dx_o + dy * dy;
    r_sq   = 8'(cr) * 8'(cr);
    crater_byte[7:4] = (dist_e <= $signed({14'd0, r_sq})) ? SKY_IDX : mem_rdata[7:4];
    crater_byte[3:0] = (dist_o <= $signed({14'd0, r_sq})) ? SKY_IDX : mem_rdata[3:0];
  end

  // Read data only arrives in the write cycle, so the crater byte is merged on the
  // way out; fill data comes straight from a register.
  assign mem_wdata = (state == CR_WR) ? crater_byte : wdata_q;
  assign dbg_state = state;

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  // Next state, next byte position and next registered port values.
  always_comb begin
    state_d   = state;
    nxt_y     = cur_y;
    nxt_xb    = cur_xb;
    we_d      = 1'b0;
    busy_d    = busy;
    done_d    = 1'b0;
    latch_req = 1'b0;
    unique case (state)
      IDLE: begin
        busy_d = 1'b0;
        if (fill_start) begin
          state_d = FILL;
          nxt_y   = 8'd0;
          nxt_xb  = 8'd0;
          we_d    = 1'b1;
          busy_d  = 1'b1;
        end else if (crater_req) begin
          state_d   = CR_RD;
          nxt_y     = req_row_lo;
          nxt_xb    = req_bcol_lo;
          busy_d    = 1'b1;
          latch_req = 1'b1;
        end
      end
      FILL: begin
        if (cur_y == LAST_ROW && cur_xb == LAST_BCOL) begin
          state_d = IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else begin
          we_d = 1'b1;
          if (cur_xb == LAST_BCOL) begin
            nxt_xb = 8'd0;
            nxt_y  = cur_y + 8'd1;
          end else begin
            nxt_xb = cur_xb + 8'd1;
          end
        end
      end
      CR_RD: begin
        state_d = CR_WR;
        we_d    = 1'b1;
      end
      CR_WR: begin
        if (cur_y == row_hi && cur_xb == bcol_hi) begin
          state_d = IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else begin
          state_d = CR_RD;
          if (cur_xb == bcol_hi) begin
            nxt_xb = bcol_lo;
            nxt_y  = cur_y + 8'd1;
          end else begin
            nxt_xb = cur_xb + 8'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, position and registered memory-port outputs.
  always_ff @(posedge VGA_Clk or posedge Reset) begin
    if (Reset) begin
      state    <= IDLE;
      cur_y    <= 8'd0;
      cur_xb   <= 8'd0;
      mem_addr <= 16'd0;
      mem_we   <= 1'b0;
      wdata_q  <= 8'd0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      state    <= state_d;
      cur_y    <= nxt_y;
      cur_xb   <= nxt_xb;
      mem_addr <= byte_addr(nxt_y, nxt_xb);
      mem_we   <= we_d;
      busy     <= busy_d;
      done     <= done_d;
      if (state_d == FILL)
        wdata_q <= fill_byte;
    end
  end

  // Crater parameters, held for the whole operation.
  always_ff @(posedge VGA_Clk or posedge Reset) begin
    if (Reset) begin
      cx      <= 9'd0;
      cy      <= 8'd0;
      cr      <= 4'd0;
      row_lo  <= 8'd0;
      row_hi  <= 8'd0;
      bcol_lo <= 8'd0;
      bcol_hi <= 8'd0;
    end else if (latch_req) begin
      cx      <= crater_x;
      cy      <= crater_y;
      cr      <= crater_r;
      row_lo  <= req_row_lo;
      row_hi  <= req_row_hi;
      bcol_lo <= req_bcol_lo;
      bcol_hi <= req_bcol_hi;
    end
  end

endmodule

// File: tb/tb_bg_painter.sv
// Self-checking bench for bg_painter with a behavioural dual-port OCM.
module tb_bg_painter;
  import bg_pkg::*;

  localparam int NB = 38400;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic VGA_Clk = 1'b0;
  logic Reset   = 1'b1;
  always #5 VGA_Clk = ~VGA_Clk;

  logic        fill_start = 1'b0;
  logic        crater_req = 1'b0;
  logic [8:0]  crater_x   = '0;
  logic [7:0]  crater_y   = '0;
  logic [3:0]  crater_r   = '0;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_we;
  logic [7:0]  mem_rdata = '0;
  logic        busy;
  logic        done;
  bg_state_t   dbg_state;

  bg_painter dut (
    .VGA_Clk    (VGA_Clk),
    .Reset      (Reset),
    .fill_start (fill_start),
    .crater_req (crater_req),
    .crater_x   (crater_x),
    .crater_y   (crater_y),
    .crater_r   (crater_r),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_we     (mem_we),
    .mem_rdata  (mem_rdata),
    .busy       (busy),
    .done       (done),
    .dbg_state  (dbg_state)
  );

  // Behavioural OCM: one-cycle read latency, read returns the old contents.
  logic [7:0] mem [NB];
  initial for (int i = 0; i < NB; i++) mem[i] = 8'h00;
  always @(posedge VGA_Clk) begin
    if (int'(mem_addr) < NB) begin
      mem_rdata <= mem[mem_addr];
      if (mem_we) mem[mem_addr] <= mem_wdata;
    end
  end

  // ---------------------------------------------------------------------------
  // Scoreboard
  // ---------------------------------------------------------------------------
  int n_vec = 0;
  int n_bad = 0;
  logic [23:0] exp_q[$];      // {addr, data} of each expected write, in order
  logic        crater_mode = 1'b0;
  logic [15:0] last_rd_addr = '0;
  int          done_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: pop and compare on every write the DUT presents.
  always @(negedge VGA_Clk) begin
    logic [23:0] e;
    if (done) done_cnt++;
    if (!Reset && busy && !mem_we) last_rd_addr = mem_addr;
    if (!Reset && mem_we) begin
      check("addr_range", {31'd0, int'(mem_addr) < NB}, 32'd1);
      if (exp_q.size() == 0) begin
        n_vec++;
        n_bad++;
        $display("FAIL spurious_write: got addr %0d data %0h, expected no write", mem_addr, mem_wdata);
      end else begin
        e = exp_q.pop_front();
        check("wr_addr", {16'd0, mem_addr}, {16'd0, e[23:8]});
        check("wr_data", {24'd0, mem_wdata}, {24'd0, e[7:0]});
        if (crater_mode) check("rmw_addr", {16'd0, mem_addr}, {16'd0, last_rd_addr});
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Expected-value generation
  // ---------------------------------------------------------------------------
  function automatic logic [3:0] ref_pix(input int x, input int y);
    int g;
    g = 150 + (((x - 160) * (x - 160)) >> 9);
    if (y < g) return 4'h1;
    else if (y < g + 4) return 4'h2;
    else return 4'h3;
  endfunction

  task automatic push_fill();
    for (int y = 0; y < 240; y++)
      for (int xb = 0; xb < 160; xb++)
        exp_q.push_back({16'(y * 160 + xb), ref_pix(2 * xb, y), ref_pix(2 * xb + 1, y)});
  endtask

  task automatic push_crater(input int cx, input int cy, input int r);
    int ylo, yhi, xblo, xbhi, a, x;
    logic [7:0] d;
    ylo  = (cy - r < 0) ? 0 : cy - r;
    yhi  = (cy + r > 239) ? 239 : cy + r;
    xblo = ((cx - r < 0) ? 0 : cx - r) / 2;
    xbhi = ((cx + r > 319) ? 319 : cx + r) / 2;
    for (int y = ylo; y <= yhi; y++)
      for (int xb = xblo; xb <= xbhi; xb++) begin
        a = y * 160 + xb;
        d = mem[a];
        for (int k = 0; k < 2; k++) begin
          x = 2 * xb + k;
          if ((x - cx) * (x - cx) + (y - cy) * (y - cy) <= r * r) begin
            if (k == 0) d[7:4] = 4'h1; else d[3:0] = 4'h1;
          end
        end
        exp_q.push_back({16'(a), d});
      end
  endtask

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  // Pulse the request lines for one cycle; returns #1 into the following cycle.
  task automatic issue(input logic f, input logic c, input logic [8:0] x,
                       input logic [7:0] y, input logic [3:0] r);
    @(posedge VGA_Clk); #1;
    fill_start = f;
    crater_req = c;
    crater_x   = x;
    crater_y   = y;
    crater_r   = r;
    @(posedge VGA_Clk); #1;
    fill_start = 1'b0;
    crater_req = 1'b0;
  endtask

  // Follow an operation until done; t is the cycle offset from the request cycle.
  task automatic run_op(input int budget, input int inject_at, input int reset_at,
                        output int t, output int busy_cyc, output int gap_cyc);
    t = 1;
    busy_cyc = 0;
    gap_cyc = 0;
    forever begin
      if (done) break;
      if (busy) busy_cyc++;
      if (busy && !mem_we) gap_cyc++;
      if (t == reset_at) begin
        #2 Reset = 1'b1;
        #1;
        check("reset_we", {31'd0, mem_we}, 32'd0);
        check("reset_busy", {31'd0, busy}, 32'd0);
        break;
      end
      if (t >= budget) begin
        n_vec++;
        n_bad++;
        $display("FAIL op_timeout: got no done after %0d cycles, expected done", t);
        break;
      end
      if (t == inject_at) begin
        crater_x = 9'd100;
        crater_y = 8'd100;
        crater_r = 4'd5;
        crater_req = 1'b1;
      end else begin
        crater_req = 1'b0;
      end
      @(posedge VGA_Clk); #1;
      t++;
    end
    crater_req = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge VGA_Clk);
    #1;
  endtask

  // ---------------------------------------------------------------------------
  // Test sequence
  // ---------------------------------------------------------------------------
  initial begin
    int t, bc, gc, d0;

    // Reset state
    idle(3);
    check("rst_addr",  {16'd0, mem_addr}, 32'd0);
    check("rst_wdata", {24'd0, mem_wdata}, 32'd0);
    check("rst_we",    {31'd0, mem_we}, 32'd0);
    check("rst_busy",  {31'd0, busy}, 32'd0);
    check("rst_done",  {31'd0, done}, 32'd0);
    check("rst_state", {30'd0, dbg_state}, {30'd0, IDLE});
    Reset = 1'b0;
    idle(2);

    // Fill and crater in the same cycle: fill wins; reset lands at fill cycle 5000.
    push_fill();
    issue(1'b1, 1'b1, 9'd160, 8'd150, 4'd5);
    check("both_first_we",   {31'd0, mem_we}, 32'd1);
    check("both_first_addr", {16'd0, mem_addr}, 32'd0);
    run_op(40000, -1, 5000, t, bc, gc);
    check("both_no_reads", gc, 0);
    check("abort_writes_left", exp_q.size(), NB - 4999);
    check("abort_state", {30'd0, dbg_state}, {30'd0, IDLE});
    exp_q.delete();
    idle(2);
    Reset = 1'b0;
    idle(2);

    // Full fill after reset; a crater_req at fill cycle 100 must be ignored.
    push_fill();
    d0 = done_cnt;
    issue(1'b1, 1'b0, 9'd0, 8'd0, 4'd0);
    check("fill_first_busy", {31'd0, busy}, 32'd1);
    check("fill_first_addr", {16'd0, mem_addr}, 32'd0);
    run_op(40000, 100, -1, t, bc, gc);
    check("fill_done_cycle", t, 38401);
    check("fill_busy_cycles", bc, 38400);
    check("fill_no_reads", gc, 0);
    check("fill_done_busy", {31'd0, busy}, 32'd0);
    idle(1);
    check("fill_done_width", {31'd0, done}, 32'd0);
    idle(40);
    check("fill_one_done", done_cnt - d0, 1);
    check("fill_q_empty", exp_q.size(), 0);
    check("byte_0",     {24'd0, mem[0]},     32'h11);
    check("byte_24080", {24'd0, mem[24080]}, 32'h22);
    check("byte_31920", {24'd0, mem[31920]}, 32'h33);

    crater_mode = 1'b1;

    // Single-pixel crater on the grass at the screen centre.
    exp_q.push_back({16'd24080, 8'h12});
    issue(1'b0, 1'b1, 9'd160, 8'd150, 4'd0);
    check("r0_read_we",   {31'd0, mem_we}, 32'd0);
    check("r0_read_addr", {16'd0, mem_addr}, 32'd24080);
    run_op(100, -1, -1, t, bc, gc);
    check("r0_done_cycle", t, 3);
    check("r0_q_empty", exp_q.size(), 0);
    idle(2);

    // Corner crater clamped to 8 bytes of sky.
    foreach (mem[i]) ;
    exp_q.push_back({16'd0,   8'h11});
    exp_q.push_back({16'd1,   8'h11});
    exp_q.push_back({16'd160, 8'h11});
    exp_q.push_back({16'd161, 8'h11});
    exp_q.push_back({16'd320, 8'h11});
    exp_q.push_back({16'd321, 8'h11});
    exp_q.push_back({16'd480, 8'h11});
    exp_q.push_back({16'd481, 8'h11});
    issue(1'b0, 1'b1, 9'd0, 8'd0, 4'd3);
    run_op(100, -1, -1, t, bc, gc);
    check("c00_done_cycle", t, 17);
    check("c00_busy_cycles", bc, 16);
    check("c00_reads", gc, 8);
    check("c00_q_empty", exp_q.size(), 0);
    idle(2);

    // Bottom-right crater in the dirt, clamped to 128 bytes.
    push_crater(319, 239, 15);
    issue(1'b0, 1'b1, 9'd319, 8'd239, 4'd15);
    run_op(400, -1, -1, t, bc, gc);
    check("cbr_done_cycle", t, 257);
    check("cbr_busy_cycles", bc, 256);
    check("cbr_reads", gc, 128);
    check("cbr_q_empty", exp_q.size(), 0);
    idle(2);
    check("cbr_y239_x318", {24'd0, mem[239 * 160 + 159]}, 32'h11);
    check("cbr_y224_x318", {24'd0, mem[224 * 160 + 159]}, 32'h31);
    check("cbr_y224_x304", {24'd0, mem[224 * 160 + 152]}, 32'h33);
    check("cbr_y239_x304", {24'd0, mem[239 * 160 + 152]}, 32'h11);
    check("final_state", {30'd0, dbg_state}, {30'd0, IDLE});

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
